// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between game-logic requesters and the shared countdown timer.
// master = requester side (drives req/req_len), slave = timer side (drives grant/status).
interface timer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 32
) ();
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [OW-1:0]            owner;
  logic [LEN_W-1:0]         remaining;

  modport master (
    output req, req_len,
    input  grant, done, busy, owner, remaining
  );

  modport slave (
    input  req, req_len,
    output grant, done, busy, owner, remaining
  );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin shared seconds countdown; grant 1 cycle after req, held L*CYCLES_PER_SEC+1 cycles, then 1-cycle done.
// No backpressure: req is level-held by the owner; with TIMER_ARBITER_ABORT_EN the owner may drop req to abort the run.
module timer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CYCLES_PER_SEC = 50000000,
  parameter int LEN_W          = 32
) (
  input  logic           clock,
  input  logic           reset,
  timer_arbiter_if.slave bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PW-1:0]      PRESC_MAX = PW'(CYCLES_PER_SEC - 1);
  localparam logic [OW-1:0]      LAST_IDX  = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [PW-1:0]    presc_q, presc_d;

  logic             any_req;
  logic [OW-1:0]    win_idx;
  logic [LEN_W-1:0] win_len;
  logic [OW-1:0]    next_ptr;
  logic [OW:0]      scan_idx;

  // Scan from the pointer upward with wrap; the first set bit wins.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (OW+1)'(k);
      if (scan_idx >= (OW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (OW+1)'(NUM_REQ);
      end
      if (!any_req && bus.req[scan_idx[OW-1:0]]) begin
        any_req = 1'b1;
        win_idx = scan_idx[OW-1:0];
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == OW'(i)) begin
        win_len = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // The finishing owner drops to lowest priority on the next arbitration.
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_RUN;
          owner_d     = win_idx;
          remaining_d = win_len;
          presc_d     = '0;
        end
      end
      ST_RUN: begin
`ifdef TIMER_ARBITER_ABORT_EN
        if (!bus.req[owner_q]) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          presc_d     = '0;
          ptr_d       = next_ptr;
        end else
`endif
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (presc_q == PRESC_MAX) begin
          presc_d     = '0;
          remaining_d = remaining_q - LEN_W'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = next_ptr;
        presc_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      remaining_q <= '0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
    end
  end

  // Outputs decode straight from state flops so reset clears them without a clock edge.
  assign bus.grant     = (state_q == ST_RUN)  ? (ONE_HOT0 << owner_q) : '0;
  assign bus.done      = (state_q == ST_DONE) ? (ONE_HOT0 << owner_q) : '0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.owner     = owner_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with CYCLES_PER_SEC=4, NUM_REQ=4.
// Abort expectations follow TIMER_ARBITER_ABORT_EN when it is defined for the build.
module tb_timer_arbiter;
  localparam int NUM_REQ = 4;
  localparam int CPS     = 4;
  localparam int LEN_W   = 32;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  timer_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

  timer_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CYCLES_PER_SEC(CPS),
    .LEN_W(LEN_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lens(input logic [31:0] l0, input logic [31:0] l1,
                          input logic [31:0] l2, input logic [31:0] l3);
    bus.req_len = {l3, l2, l1, l0};
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.req  = '0;
    set_lens(0, 0, 0, 0);

    // Reset state and a single len=2 run
    do_reset();
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_remaining", bus.remaining, 0);

    set_lens(2, 0, 0, 0);
    bus.req = 4'b0001;
    check("t1_no_grant_yet", bus.grant, 0);
    tick();
    for (int j = 0; j < 9; j++) begin
      check("t1_grant", bus.grant, 4'b0001);
      check("t1_busy", bus.busy, 1);
      check("t1_remaining", bus.remaining, (j < 4) ? 2 : (j < 8) ? 1 : 0);
      tick();
    end
    check("t1_grant_off", bus.grant, 0);
    check("t1_done", bus.done, 4'b0001);
    check("t1_done_busy", bus.busy, 1);
    bus.req = '0;
    tick();
    check("t1_done_pulse_end", bus.done, 0);
    check("t1_idle_busy", bus.busy, 0);
    check("t1_owner_kept", bus.owner, 0);
    tick();
    check("t1_no_regrant", bus.grant, 0);

    // Round robin over all four with zero lengths
    do_reset();
    set_lens(0, 0, 0, 0);
    bus.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_grant", bus.grant, 4'b0001 << (i % 4));
      check("t2_owner", bus.owner, i % 4);
      check("t2_remaining", bus.remaining, 0);
      tick();
      check("t2_done", bus.done, 4'b0001 << (i % 4));
      check("t2_done_grant", bus.grant, 0);
      tick();
      check("t2_idle_grant", bus.grant, 0);
      check("t2_idle_busy", bus.busy, 0);
      tick();
    end
    bus.req = '0;

    // Asynchronous reset mid-run
    do_reset();
    set_lens(0, 0, 5, 0);
    bus.req = 4'b0100;
    tick();
    check("t3_grant", bus.grant, 4'b0100);
    check("t3_remaining", bus.remaining, 5);
    for (int j = 0; j < 7; j++) tick();
    check("t3_mid_remaining", bus.remaining, 4);
    reset = 1'b1;
    #1;
    check("t3_async_grant", bus.grant, 0);
    check("t3_async_busy", bus.busy, 0);
    check("t3_async_remaining", bus.remaining, 0);
    check("t3_async_done", bus.done, 0);
    tick();
    check("t3_no_done", bus.done, 0);
    reset = 1'b0;
    set_lens(1, 0, 5, 0);
    bus.req = 4'b0101;
    tick();
    check("t3_regrant", bus.grant, 4'b0001);
    check("t3_regrant_owner", bus.owner, 0);
    check("t3_regrant_remaining", bus.remaining, 1);

    // req2 rising during requester 1's DONE cycle
    do_reset();
    set_lens(0, 1, 3, 0);
    bus.req = 4'b0010;
    tick();
    check("t4_grant1", bus.grant, 4'b0010);
    for (int j = 0; j < 5; j++) tick();
    check("t4_done1", bus.done, 4'b0010);
    bus.req = 4'b0100;
    tick();
    check("t4_idle_gap", bus.grant, 0);
    tick();
    check("t4_grant2", bus.grant, 4'b0100);
    check("t4_owner2", bus.owner, 2);
    check("t4_remaining2", bus.remaining, 3);

    // Owner drops req mid-run
    do_reset();
    set_lens(0, 3, 0, 0);
    bus.req = 4'b0010;
    tick();
    check("t5_grant", bus.grant, 4'b0010);
    for (int j = 0; j < 4; j++) tick();
    check("t5_remaining_j4", bus.remaining, 2);
    bus.req = '0;
    tick();
`ifdef TIMER_ARBITER_ABORT_EN
    check("t5_abort_grant", bus.grant, 0);
    check("t5_abort_remaining", bus.remaining, 0);
    check("t5_abort_busy", bus.busy, 0);
    check("t5_abort_done", bus.done, 0);
    bus.req = 4'b0011;
    tick();
`else
    for (int j = 5; j < 12; j++) tick();
    check("t5_last_grant", bus.grant, 4'b0010);
    check("t5_last_remaining", bus.remaining, 0);
    tick();
    check("t5_done_c13", bus.done, 4'b0010);
    bus.req = 4'b0011;
    tick();
    check("t5_idle_gap", bus.grant, 0);
    tick();
`endif
    check("t5_ptr_after_owner1", bus.grant, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one seconds-granularity countdown timer between NUM_REQ requesters in the game logic, such as note-window, round and countdown-display controllers.
- Arbitrates requests round-robin, latches the winner's length, runs the countdown from a cycle prescaler, then signals completion to that requester only.
- Replaces per-requester free-running timers with a single prescaler and counter.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CYCLES_PER_SEC, 50000000: clock cycles per counted second (50 MHz board clock).
- LEN_W, 32: width of length and remaining-seconds fields.

Ports:
- clock, input, 1: single system clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, NUM_REQ: level request, one bit per requester; held high until done or grant loss.
- req_len, input, NUM_REQ*LEN_W: packed lengths in seconds; slice i = req_len[i*LEN_W +: LEN_W]; sampled only at grant.
- grant, output, NUM_REQ: one-hot; bit i high while requester i owns the timer.
- done, output, NUM_REQ: one-cycle pulse to the owner on normal expiry.
- busy, output, 1: high in RUN and DONE.
- owner, output, clog2(NUM_REQ): index of the current or last owner.
- remaining, output, LEN_W: whole seconds left for the current owner; 0 when idle.

Behaviour:
- Reset (async, active-high) applies immediately, including mid-run:
  - state = IDLE; grant = 0, done = 0, busy = 0, owner = 0, remaining = 0.
  - Prescaler = 0; round-robin pointer = 0, so requester 0 has highest priority.
  - No done pulse is generated for an interrupted run.
- States are IDLE, RUN and DONE.
- IDLE:
  - If any req bit is high, select the first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - Latch remaining = req_len slice of the winner; owner = winner; prescaler = 0; go to RUN.
  - grant[owner] and busy rise the cycle after req is sampled (1-cycle grant latency).
  - If no req bit is high, stay in IDLE; outputs hold their reset values except owner, which keeps the last value.
- RUN:
  - Prescaler counts 0..CYCLES_PER_SEC-1. On reaching CYCLES_PER_SEC-1 it wraps to 0 and remaining decrements by 1 in the same cycle.
  - When remaining == 0 at a clock edge, go to DONE.
  - A run of length L therefore holds grant for exactly L*CYCLES_PER_SEC+1 cycles.
  - L = 0 gives a grant of 1 cycle.
  - Remaining never underflows; the decrement is suppressed at 0.
  - req changes and other requesters' req/req_len are ignored during RUN (see Optional Feature).
- DONE:
  - Lasts exactly one cycle: grant = 0, done[owner] = 1, busy = 1.
  - pointer = owner+1 mod NUM_REQ; go to IDLE.
- After DONE, at least one IDLE cycle precedes the next grant, so the minimum back-to-back spacing between grants is 2 cycles.
- Arbitration:
  - The requester that just finished has lowest priority for the next grant.
  - A requester whose req stays high is re-granted only if no other req is pending.
- Simultaneous events:
  - A req rising in the same cycle as DONE is not considered until the IDLE cycle.
  - A req deasserted in that same IDLE cycle is not granted.
- Widths:
  - Prescaler width is clog2(CYCLES_PER_SEC); no wider counter is used.
  - req_len is treated as unsigned.

Optional Feature:
- Macro: TIMER_ARBITER_ABORT_EN.
- Defined: in RUN, if req[owner] is sampled low, the run is aborted.
  - Next cycle grant = 0, busy = 0, remaining = 0, and state returns directly to IDLE.
  - No done pulse is issued; pointer = owner+1.
  - Abort takes priority over expiry in the same cycle.
- Not defined: req[owner] is ignored during RUN and every granted run ends in DONE with a done pulse.

Test Plan (CYCLES_PER_SEC=4, NUM_REQ=4):
- Reset in IDLE, then req=0001 with len0=2:
  - Required: grant=0001 one cycle after req.
  - remaining 2 -> 1 -> 0 at 4-cycle steps; grant high for 9 cycles.
  - done=0001 for 1 cycle; busy low afterwards.
- req=1111 held, all lengths 0:
  - Required: grants 0001, 0010, 0100, 1000, 0001 in order.
  - Each grant lasts 1 cycle; the done pulse follows each grant; grants are 3 cycles apart.
- req=0100 with len=5, then reset asserted 7 cycles into RUN:
  - Required: grant/busy/remaining go to 0 without waiting for a clock edge; no done pulse.
  - After reset, with req=0101, the grant goes to requester 0.
- Requester 1 running len=1 while req2 rises in the DONE cycle:
  - Required: grant=0100 two cycles after the done pulse.
  - owner=2; remaining=len2.
- With TIMER_ARBITER_ABORT_EN, grant=0010 with len=3, req[1] dropped 5 cycles in:
  - Required: grant=0 and remaining=0 the next cycle; done stays 0.
  - Without the macro, the same stimulus runs to completion with done=0010 at cycle 13.
